wb_regfile: RTL and testbench

Writeback-stage register file for the 5-stage RV32I pipeline. It consumes the W-stage outputs of the MEM/WB pipeline register, selects the writeback value, commits it to the 32×32 architectural register file, and serves the decode stage's two read ports. Same-cycle writes are forwarded to the read ports, so ID never reads a stale value for a register being written in WB. The block also keeps a committed-write counter and a sticky illegal-select flag for debug.

---
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// wb_regfile : RV32I writeback stage + 32x32 register file with WB->ID bypass
// Revision   : 1.0
// ============================================================================
module wb_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            reg_wr_W,
   input  logic [1:0]      sel_wb_W,
   input  logic [XLEN-1:0] alu_o_W,
   input  logic [XLEN-1:0] rd_data_W,
   input  logic [XLEN-1:0] PC4_W,
   input  logic [4:0]      rd_W,
   input  logic [4:0]      rs1_D,
   input  logic [4:0]      rs2_D,
   output logic [XLEN-1:0] rs1_data_D,
   output logic [XLEN-1:0] rs2_data_D,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic [XLEN-1:0] wb_data,
   output logic [31:0]     wb_count,
   output logic            illegal_wb
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;
   localparam logic [1:0] SEL_RSVD = 2'b11;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [31:0]     wb_count_q, wb_count_d;
   logic            illegal_q, illegal_d;
   logic            we;

   always_comb begin
      case (sel_wb_W)
         SEL_ALU:  wb_data = alu_o_W;
         SEL_LOAD: wb_data = rd_data_W;
         SEL_PC4:  wb_data = PC4_W;
         default:  wb_data = '0;
      endcase
   end

   assign we = reg_wr_W & (rd_W != 5'd0) & (sel_wb_W != SEL_RSVD);

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[rd_W] = wb_data;
      end
      regs_d[0]  = '0;
      wb_count_d = wb_count_q + {31'd0, we};
      illegal_d  = illegal_q | (reg_wr_W & (sel_wb_W == SEL_RSVD));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wb_count_q <= '0;
         illegal_q  <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         wb_count_q <= wb_count_d;
         illegal_q  <= illegal_d;
      end
   end

   // x0 stays zero in the array, so only the bypass needs the rd_W != 0 guard (inside we)
   always_comb begin
      rs1_data_D = (we && (rs1_D == rd_W)) ? wb_data : regs_q[rs1_D];
      rs2_data_D = (we && (rs2_D == rd_W)) ? wb_data : regs_q[rs2_D];
      if (rs1_D == 5'd0) rs1_data_D = '0;
      if (rs2_D == 5'd0) rs2_data_D = '0;
   end

   assign dbg_data   = regs_q[dbg_addr];
   assign wb_count   = wb_count_q;
   assign illegal_wb = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// tb_wb_regfile : table vectors, hand corner sequences and a randomized run
// checked against an array-based reference model.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reg_wr_W = 1'b0;
   logic [1:0]  sel_wb_W = 2'b00;
   logic [31:0] alu_o_W = '0, rd_data_W = '0, PC4_W = '0;
   logic [4:0]  rd_W = '0, rs1_D = '0, rs2_D = '0, dbg_addr = '0;
   logic [31:0] rs1_data_D, rs2_data_D, dbg_data, wb_data, wb_count;
   logic        illegal_wb;

   wb_regfile #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst(rst), .reg_wr_W(reg_wr_W), .sel_wb_W(sel_wb_W),
      .alu_o_W(alu_o_W), .rd_data_W(rd_data_W), .PC4_W(PC4_W), .rd_W(rd_W),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_data_D(rs1_data_D), .rs2_data_D(rs2_data_D),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_data(wb_data),
      .wb_count(wb_count), .illegal_wb(illegal_wb)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_count;
   logic        m_ill;

   typedef struct {
      logic        wr;
      logic [1:0]  sel;
      logic [31:0] alu, ld, pc4;
      logic [4:0]  rd, rs1, rs2, dbg;
      logic [31:0] e_wb, e_rs1, e_rs2, e_dbg0, e_dbg1, e_cnt;
      logic        e_ill;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_wb();
      case (sel_wb_W)
         2'd0:    return alu_o_W;
         2'd1:    return rd_data_W;
         2'd2:    return PC4_W;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_we();
      return reg_wr_W && rd_W != 0 && sel_wb_W != 2'd3;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (m_we() && a == rd_W) return m_wb();
      return m_regs[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_count = '0;
      m_ill   = 1'b0;
   endtask

   // model effect of the coming edge, using the inputs currently applied
   task automatic m_commit();
      if (rst) begin
         if (m_we()) begin
            m_regs[rd_W] = m_wb();
            m_count      = m_count + 1;
         end
         if (reg_wr_W && sel_wb_W == 2'd3) m_ill = 1'b1;
      end
   endtask

   task automatic drive(input logic wr, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc4, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
      reg_wr_W = wr; sel_wb_W = sel; alu_o_W = alu; rd_data_W = ld; PC4_W = pc4;
      rd_W = rd; rs1_D = r1; rs2_D = r2; dbg_addr = dbg;
   endtask

   task automatic bubble();
      reg_wr_W = 1'b0;
   endtask

   // one checked cycle against the model; called right after a negedge with inputs driven
   task automatic model_cycle(input string tag);
      #1;
      chk({tag, " wb_data"}, wb_data, m_wb());
      chk({tag, " rs1"}, rs1_data_D, m_read(rs1_D));
      chk({tag, " rs2"}, rs2_data_D, m_read(rs2_D));
      chk({tag, " dbg"}, dbg_data, m_regs[dbg_addr]);
      m_commit();
      @(posedge clk); #1;
      chk({tag, " count"}, wb_count, m_count);
      chk({tag, " illegal"}, {31'd0, illegal_wb}, {31'd0, m_ill});
      chk({tag, " dbg post"}, dbg_data, m_regs[dbg_addr]);
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{1'b1, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0, 5'd5,
                  32'h0000_1234, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 32'd1, 1'b0};
      vecs[1] = '{1'b1, 2'd1, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd6, 5'd5, 5'd6, 5'd6,
                  32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'd2, 1'b0};
      vecs[2] = '{1'b1, 2'd2, 32'h0, 32'h0, 32'h0000_0104, 5'd7, 5'd7, 5'd6, 5'd7,
                  32'h0000_0104, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 32'h0000_0104, 32'd3, 1'b0};
      vecs[3] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 5'd0,
                  32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 32'h0, 32'h0, 32'd3, 1'b0};
      vecs[4] = '{1'b1, 2'd3, 32'h77, 32'h88, 32'h99, 5'd8, 5'd8, 5'd8, 5'd8,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd3, 1'b1};
      vecs[5] = '{1'b1, 2'd0, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd10, 5'd10, 5'd10, 5'd10,
                  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'd4, 1'b1};
      vecs[6] = '{1'b0, 2'd0, 32'h1, 32'h0, 32'h0, 5'd10, 5'd10, 5'd5, 5'd10,
                  32'h1, 32'hA5A5_A5A5, 32'h0000_1234, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd4, 1'b1};
      vecs[7] = '{1'b1, 2'd1, 32'h0, 32'hCAFE_0000, 32'h0, 5'd5, 5'd5, 5'd10, 5'd5,
                  32'hCAFE_0000, 32'hCAFE_0000, 32'hA5A5_A5A5, 32'h0000_1234, 32'hCAFE_0000, 32'd5, 1'b1};

      // reset held with random writes in flight
      m_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
               5'($urandom_range(1, 31)), 5'd0, 5'd0, 5'd0);
      end
      @(negedge clk);
      bubble();
      rst = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rs1_D = 5'(a); rs2_D = 5'(31 - a); dbg_addr = 5'(a);
         #1;
         chk("reset rs1", rs1_data_D, 32'd0);
         chk("reset rs2", rs2_data_D, 32'd0);
         chk("reset dbg", dbg_data, 32'd0);
      end
      chk("reset count", wb_count, 32'd0);
      chk("reset illegal", {31'd0, illegal_wb}, 32'd0);

      // table vectors
      @(negedge clk);
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].wr, vecs[v].sel, vecs[v].alu, vecs[v].ld, vecs[v].pc4,
               vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].dbg);
         #1;
         chk($sformatf("vec%0d wb_data", v), wb_data, vecs[v].e_wb);
         chk($sformatf("vec%0d rs1", v), rs1_data_D, vecs[v].e_rs1);
         chk($sformatf("vec%0d rs2", v), rs2_data_D, vecs[v].e_rs2);
         chk($sformatf("vec%0d dbg pre", v), dbg_data, vecs[v].e_dbg0);
         m_commit();
         @(posedge clk); #1;
         chk($sformatf("vec%0d dbg post", v), dbg_data, vecs[v].e_dbg1);
         chk($sformatf("vec%0d count", v), wb_count, vecs[v].e_cnt);
         chk($sformatf("vec%0d illegal", v), {31'd0, illegal_wb}, {31'd0, vecs[v].e_ill});
         @(negedge clk);
      end

      // illegal flag is sticky across idle cycles; x6/x7 still hold their values
      bubble();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("illegal sticky", {31'd0, illegal_wb}, 32'd1);
      end
      dbg_addr = 5'd7; #1;
      chk("x7 hold", dbg_data, 32'h0000_0104);

      // randomized run against the model
      for (int i = 0; i < 300; i++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
               $urandom, rd,
               ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31)));
         model_cycle("rand");
      end

      // counter wrap: preload near the top, then three writes
      bubble();
      @(negedge clk);
      dut.wb_count_q = 32'hFFFF_FFFE;
      m_count = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd0, 32'h100 + 32'(i), 32'h0, 32'h0, 5'd20, 5'd20, 5'd0, 5'd20);
         model_cycle("wrap");
      end
      chk("wrap final", wb_count, 32'd1);

      // async reset mid-stream with a write to x9 pending across the edge
      drive(1'b1, 2'd0, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0, 5'd3);
      model_cycle("pre x3");
      drive(1'b1, 2'd0, 32'h66, 32'h0, 32'h0, 5'd4, 5'd4, 5'd3, 5'd4);
      model_cycle("pre x4");
      drive(1'b1, 2'd0, 32'h99, 32'h0, 32'h0, 5'd9, 5'd3, 5'd4, 5'd9);
      #1 rst = 1'b0;
      #1;
      m_reset();
      chk("arst x3", rs1_data_D, 32'd0);
      chk("arst x4", rs2_data_D, 32'd0);
      chk("arst x9 dbg", dbg_data, 32'd0);
      chk("arst count", wb_count, 32'd0);
      chk("arst illegal", {31'd0, illegal_wb}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      chk("arst x9 after edge", dbg_data, 32'd0);
      chk("arst count after edge", wb_count, 32'd0);
      @(negedge clk);
      // first edge with reset released commits the pending write
      model_cycle("post arst");
      chk("post arst x9", dbg_data, 32'h99);
      chk("post arst count", wb_count, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
